// File: rtl/word_splitter_if.sv
// rtl/word_splitter_if.sv - input word and output slice streams of the word splitter
interface word_splitter_if #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 8
);
    localparam int NSLICE = IN_W / OUT_W;
    localparam int IDX_W  = $clog2(NSLICE);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              msb_first;

    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, msb_first, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, msb_first, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/word_splitter.sv
// rtl/word_splitter.sv - splits one IN_W-bit word into NSLICE OUT_W-bit slices
module word_splitter #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    word_splitter_if.slave bus
);
    localparam int NSLICE = IN_W / OUT_W;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_params
        $error("word_splitter: IN_W must be a multiple of OUT_W with at least two slices");
    end

    logic [0:0]       state_q, state_d;
    logic [IN_W-1:0]  shift_q, shift_d;
    logic             msb_q, msb_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_c;

    // shift_q always holds the not-yet-emitted slices with the next one at the
    // LSB end (LSB-first) or the MSB end (MSB-first), so each slice is a fixed select.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        msb_d       = msb_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        in_ready_c  = (state_q == S_IDLE) && !reset;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    state_d     = S_BUSY;
                    msb_d       = bus.msb_first;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_last_d  = 1'b0;
                    if (bus.msb_first) begin
                        out_data_d = bus.in_data[IN_W-1 -: OUT_W];
                        shift_d    = bus.in_data << OUT_W;
                    end else begin
                        out_data_d = bus.in_data[OUT_W-1:0];
                        shift_d    = bus.in_data >> OUT_W;
                    end
                end
            end
            S_BUSY: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                        shift_d     = '0;
                    end else begin
                        out_idx_d  = out_idx_q + 1'b1;
                        out_last_d = ((out_idx_q + 1'b1) == LAST_IDX);
                        if (msb_q) begin
                            out_data_d = shift_q[IN_W-1 -: OUT_W];
                            shift_d    = shift_q << OUT_W;
                        end else begin
                            out_data_d = shift_q[OUT_W-1:0];
                            shift_d    = shift_q >> OUT_W;
                        end
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            msb_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            msb_q       <= msb_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_word_splitter.sv
// tb/tb_word_splitter.sv - directed and randomized-backpressure bench for word_splitter
module tb_word_splitter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    word_splitter_if #(.IN_W(256), .OUT_W(8)) bus_w ();
    word_splitter_if #(.IN_W(32),  .OUT_W(8)) bus_n ();

    word_splitter #(.IN_W(256), .OUT_W(8)) u_wide (.clk(clk), .reset(reset), .bus(bus_w));
    word_splitter #(.IN_W(32),  .OUT_W(8)) u_narrow (.clk(clk), .reset(reset), .bus(bus_n));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] wword;
        logic [31:0]  word, acc;
        logic [7:0]   e3 [4];
        logic         msb, done, pv, pr, pl;
        logic [7:0]   pd;
        logic [4:0]   pi;
        int           k, cyc, n;

        e3[0] = 8'hEF; e3[1] = 8'hBE; e3[2] = 8'hAD; e3[3] = 8'hDE;
        bus_w.in_valid = 0; bus_w.in_data = '0; bus_w.msb_first = 0; bus_w.out_ready = 0;
        bus_n.in_valid = 0; bus_n.in_data = '0; bus_n.msb_first = 0; bus_n.out_ready = 0;
        reset = 1;
        step(); step();

        chk("rst_valid", bus_w.out_valid, 0);
        chk("rst_data",  bus_w.out_data, 0);
        chk("rst_idx",   bus_w.out_idx, 0);
        chk("rst_last",  bus_w.out_last, 0);
        chk("rst_in_ready_w", bus_w.in_ready, 0);
        chk("rst_in_ready_n", bus_n.in_ready, 0);
        reset = 0;
        #1;
        chk("post_rst_in_ready", bus_w.in_ready, 1);

        // 256'b110 LSB-first
        bus_w.out_ready = 1;
        bus_w.in_data = 256'b110; bus_w.msb_first = 0; bus_w.in_valid = 1;
        step();
        bus_w.in_valid = 0;
        for (int i = 0; i < 32; i++) begin
            chk("t1_valid", bus_w.out_valid, 1);
            chk("t1_data", bus_w.out_data, (i == 0) ? 8'h06 : 8'h00);
            chk("t1_idx", bus_w.out_idx, i);
            chk("t1_last", bus_w.out_last, (i == 31));
            step();
        end
        chk("t1_in_ready_after", bus_w.in_ready, 1);
        chk("t1_valid_after", bus_w.out_valid, 0);
        chk("t1_idx_after", bus_w.out_idx, 0);
        chk("t1_last_after", bus_w.out_last, 0);

        // same word MSB-first
        bus_w.msb_first = 1; bus_w.in_valid = 1;
        step();
        bus_w.in_valid = 0;
        for (int i = 0; i < 32; i++) begin
            chk("t2_data", bus_w.out_data, (i == 31) ? 8'h06 : 8'h00);
            chk("t2_idx", bus_w.out_idx, i);
            chk("t2_last", bus_w.out_last, (i == 31));
            step();
        end
        chk("t2_valid_after", bus_w.out_valid, 0);

        // 32'hDEADBEEF LSB-first, back-to-back words
        bus_n.out_ready = 1;
        bus_n.in_data = 32'hDEADBEEF; bus_n.msb_first = 0; bus_n.in_valid = 1;
        step();
        bus_n.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_data", bus_n.out_data, e3[i]);
            chk("t3_idx", bus_n.out_idx, i);
            chk("t3_last", bus_n.out_last, (i == 3));
            step();
        end
        chk("t3_in_ready_cycle5", bus_n.in_ready, 1);
        bus_n.in_valid = 1;
        step();
        bus_n.in_valid = 0;
        chk("t3_second_valid", bus_n.out_valid, 1);
        chk("t3_second_data", bus_n.out_data, 8'hEF);

        // backpressure at idx 2 with a spurious in_valid
        step();
        step();
        chk("t4_data_pre", bus_n.out_data, 8'hAD);
        bus_n.out_ready = 0;
        bus_n.in_valid = 1; bus_n.in_data = 32'h11111111;
        chk("t4_in_ready_busy", bus_n.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_data", bus_n.out_data, 8'hAD);
            chk("t4_stall_idx", bus_n.out_idx, 2);
            chk("t4_stall_valid", bus_n.out_valid, 1);
            chk("t4_stall_in_ready", bus_n.in_ready, 0);
        end
        bus_n.in_valid = 0;
        bus_n.out_ready = 1;
        step();
        chk("t4_data3", bus_n.out_data, 8'hDE);
        chk("t4_idx3", bus_n.out_idx, 3);
        chk("t4_last3", bus_n.out_last, 1);
        step();
        chk("t4_idle_valid", bus_n.out_valid, 0);
        chk("t4_idle_in_ready", bus_n.in_ready, 1);
        step();
        chk("t4_no_latch", bus_n.out_valid, 0);

        // reset at idx 10 of a 256-bit word
        wword = '0;
        for (int i = 0; i < 32; i++) wword[i*8 +: 8] = 8'(i + 1);
        bus_w.in_data = wword; bus_w.msb_first = 0; bus_w.in_valid = 1;
        step();
        bus_w.in_valid = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t5_idx10", bus_w.out_idx, 10);
        chk("t5_data10", bus_w.out_data, 8'h0B);
        reset = 1;
        step();
        chk("t5_rst_valid", bus_w.out_valid, 0);
        chk("t5_rst_data", bus_w.out_data, 0);
        chk("t5_rst_idx", bus_w.out_idx, 0);
        chk("t5_rst_in_ready", bus_w.in_ready, 0);
        reset = 0;
        #1;
        chk("t5_in_ready", bus_w.in_ready, 1);
        bus_w.in_data = 256'hFF; bus_w.in_valid = 1;
        step();
        bus_w.in_valid = 0;
        chk("t5_new_valid", bus_w.out_valid, 1);
        chk("t5_new_data", bus_w.out_data, 8'hFF);
        chk("t5_new_idx", bus_w.out_idx, 0);
        n = 0;
        while (bus_w.out_valid && n < 64) begin
            step();
            n++;
        end
        chk("t5_drain_done", bus_w.out_valid, 0);
        chk("t5_drain_cycles", n, 32);

        // 200 random words with random out_ready
        for (int w = 0; w < 200; w++) begin
            word = $urandom;
            msb = 1'($urandom_range(0, 1));
            n = 0;
            while (!bus_n.in_ready && n < 50) begin
                step();
                n++;
            end
            chk("t6_in_ready", bus_n.in_ready, 1);
            bus_n.in_data = word; bus_n.msb_first = msb; bus_n.in_valid = 1;
            step();
            bus_n.in_valid = 0;
            acc = '0; k = 0; done = 0; cyc = 0;
            while (!done && cyc < 200) begin
                bus_n.out_ready = 1'($urandom_range(0, 1));
                pv = bus_n.out_valid; pr = bus_n.out_ready;
                pd = bus_n.out_data; pi = 5'(bus_n.out_idx); pl = bus_n.out_last;
                step();
                cyc++;
                if (pv && pr) begin
                    chk("t6_idx", pi, k);
                    chk("t6_last", pl, (k == 3));
                    if (k < 4) begin
                        if (msb) acc[31 - k*8 -: 8] = pd;
                        else     acc[k*8 +: 8] = pd;
                    end
                    if (pl || k >= 3) done = 1;
                    k++;
                end else if (pv) begin
                    chk("t6_stall_valid", bus_n.out_valid, 1);
                    chk("t6_stall_data", bus_n.out_data, pd);
                    chk("t6_stall_idx", bus_n.out_idx, pi);
                    chk("t6_stall_last", bus_n.out_last, pl);
                end else begin
                    chk("t6_valid_busy", pv, 1);
                    done = 1;
                end
            end
            chk("t6_word_done", done, 1);
            chk("t6_reassembly", acc, word);
            chk("t6_idle_after", bus_n.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
